// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard scan-code decoder: pops bytes from the keyboard FIFO and tracks
// the most recent make/break key, press count and event pulses.
module ps2_key_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_down,
  output logic [7:0] press_cnt,
  output logic       evt_valid,
  output logic       evt_break,
  output logic       ovf_seen
);

  localparam int unsigned BYTE_W  = 8;
  localparam logic [BYTE_W-1:0] EXT_PFX = 8'hE0;
  localparam logic [BYTE_W-1:0] BRK_PFX = 8'hF0;

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t              r_state, w_state_nxt;
  logic [BYTE_W-1:0]   r_byte, w_byte_nxt;
  logic                r_ext_pend, w_ext_pend_nxt;
  logic                r_brk_pend, w_brk_pend_nxt;
  logic [BYTE_W-1:0]   r_key_code, w_key_code_nxt;
  logic                r_key_ext, w_key_ext_nxt;
  logic                r_key_down, w_key_down_nxt;
  logic [BYTE_W-1:0]   r_press_cnt, w_press_cnt_nxt;
  logic                r_evt_valid, w_evt_valid_nxt;
  logic                r_evt_break, w_evt_break_nxt;
  logic                r_nextdata_n, w_nextdata_n_nxt;
  logic                r_ovf_seen;
  logic                w_same_key;

  assign w_same_key = (r_byte == r_key_code) && (r_ext_pend == r_key_ext);

  // Next state and decode of the captured byte during POP
  always_comb begin
    w_state_nxt      = r_state;
    w_byte_nxt       = r_byte;
    w_ext_pend_nxt   = r_ext_pend;
    w_brk_pend_nxt   = r_brk_pend;
    w_key_code_nxt   = r_key_code;
    w_key_ext_nxt    = r_key_ext;
    w_key_down_nxt   = r_key_down;
    w_press_cnt_nxt  = r_press_cnt;
    w_evt_valid_nxt  = 1'b0;
    w_evt_break_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (ready) begin
          w_byte_nxt  = data;
          w_state_nxt = POP;
        end
      end
      POP: begin
        w_state_nxt = SETTLE;
        if (r_byte == EXT_PFX) begin
          w_ext_pend_nxt = 1'b1;
        end else if (r_byte == BRK_PFX) begin
          w_brk_pend_nxt = 1'b1;
        end else if (r_brk_pend) begin
          w_evt_valid_nxt = 1'b1;
          w_evt_break_nxt = 1'b1;
          if (w_same_key) w_key_down_nxt = 1'b0;
          w_ext_pend_nxt = 1'b0;
          w_brk_pend_nxt = 1'b0;
        end else if (r_key_down && w_same_key) begin
          // Typematic repeat: re-announce the make without counting a press
          w_evt_valid_nxt = 1'b1;
          w_ext_pend_nxt  = 1'b0;
        end else begin
          w_key_code_nxt  = r_byte;
          w_key_ext_nxt   = r_ext_pend;
          w_key_down_nxt  = 1'b1;
          w_press_cnt_nxt = r_press_cnt + BYTE_W'(1);
          w_evt_valid_nxt = 1'b1;
          w_ext_pend_nxt  = 1'b0;
        end
      end
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_nextdata_n_nxt = (w_state_nxt != POP);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_byte       <= '0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_key_code   <= '0;
      r_key_ext    <= 1'b0;
      r_key_down   <= 1'b0;
      r_press_cnt  <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_break  <= 1'b0;
      r_nextdata_n <= 1'b1;
      r_ovf_seen   <= 1'b0;
    end else begin
      r_byte       <= w_byte_nxt;
      r_ext_pend   <= w_ext_pend_nxt;
      r_brk_pend   <= w_brk_pend_nxt;
      r_key_code   <= w_key_code_nxt;
      r_key_ext    <= w_key_ext_nxt;
      r_key_down   <= w_key_down_nxt;
      r_press_cnt  <= w_press_cnt_nxt;
      r_evt_valid  <= w_evt_valid_nxt;
      r_evt_break  <= w_evt_break_nxt;
      r_nextdata_n <= w_nextdata_n_nxt;
      r_ovf_seen   <= r_ovf_seen | overflow;
    end
  end

  assign nextdata_n = r_nextdata_n;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_down   = r_key_down;
  assign press_cnt  = r_press_cnt;
  assign evt_valid  = r_evt_valid;
  assign evt_break  = r_evt_break;
  assign ovf_seen   = r_ovf_seen;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: FIFO model feeds bytes, a reference decoder queues
// expected events, and a monitor compares each DUT event pulse.
module tb_ps2_key_ctrl;

  logic       clk, clrn, ready, overflow;
  logic [7:0] data;
  logic       nextdata_n, key_ext, key_down, evt_valid, evt_break, ovf_seen;
  logic [7:0] key_code, press_cnt;

  ps2_key_ctrl dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .key_down(key_down), .press_cnt(press_cnt), .evt_valid(evt_valid),
    .evt_break(evt_break), .ovf_seen(ovf_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pops = 0;
  int n_make = 0;
  int n_brk = 0;

  logic [7:0]  byte_q[$];
  logic [18:0] exp_q[$];   // {break, code, ext, down, cnt}

  logic [7:0] m_code, m_cnt;
  logic       m_ext, m_down, m_ep, m_bp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    ready = (byte_q.size() != 0);
    data  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
  endtask

  task automatic model_clear();
    m_code = 8'h00; m_cnt = 8'h00; m_ext = 1'b0;
    m_down = 1'b0;  m_ep = 1'b0;   m_bp = 1'b0;
  endtask

  // Reference decoder: queue the post-event key state for every event
  task automatic push_byte(input logic [7:0] b);
    byte_q.push_back(b);
    if (b == 8'hE0) m_ep = 1'b1;
    else if (b == 8'hF0) m_bp = 1'b1;
    else if (m_bp) begin
      if (b == m_code && m_ep == m_ext) m_down = 1'b0;
      exp_q.push_back({1'b1, m_code, m_ext, m_down, m_cnt});
      m_ep = 1'b0; m_bp = 1'b0;
    end else if (m_down && b == m_code && m_ep == m_ext) begin
      exp_q.push_back({1'b0, m_code, m_ext, m_down, m_cnt});
      m_ep = 1'b0;
    end else begin
      m_code = b; m_ext = m_ep; m_down = 1'b1; m_cnt = m_cnt + 8'd1;
      exp_q.push_back({1'b0, m_code, m_ext, m_down, m_cnt});
      m_ep = 1'b0;
    end
    refresh();
  endtask

  // FIFO model: pop head when the DUT strobes nextdata_n low at an edge
  always @(posedge clk) begin
    logic pop_req;
    pop_req = !nextdata_n && clrn;
    #1;
    if (pop_req && byte_q.size() != 0) begin
      void'(byte_q.pop_front());
      pops++;
    end
    refresh();
  end

  // Event monitor
  always @(negedge clk) begin
    if (evt_valid) begin
      if (evt_break) n_brk++; else n_make++;
      if (exp_q.size() == 0) chk("unexpected_evt", 32'(evt_break) + 32'd1, 32'd0);
      else chk("evt", 32'({evt_break, key_code, key_ext, key_down, press_cnt}),
               32'(exp_q.pop_front()));
    end else if (clrn) begin
      if (evt_break) chk("brk_without_valid", 32'(evt_break), 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    byte_q.delete(); exp_q.delete(); model_clear(); refresh();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    pops = 0; n_make = 0; n_brk = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (byte_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
    chk("pending_evts", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    clrn = 1'b0; overflow = 1'b0;
    model_clear(); refresh();
    repeat (2) @(negedge clk);
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_key_code", 32'(key_code), 32'h00);
    chk("rst_key_down", 32'(key_down), 32'd0);
    chk("rst_press_cnt", 32'(press_cnt), 32'd0);
    chk("rst_evt", 32'({evt_valid, evt_break}), 32'd0);
    chk("rst_ovf", 32'(ovf_seen), 32'd0);
    clrn = 1'b1;

    // Single make
    push_byte(8'h1C);
    drain();
    chk("t1_pops", 32'(pops), 32'd1);
    chk("t1_code", 32'(key_code), 32'h1C);
    chk("t1_down", 32'(key_down), 32'd1);
    chk("t1_cnt", 32'(press_cnt), 32'd1);

    // Typematic repeat then release
    do_reset();
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    push_byte(8'hF0); push_byte(8'h1C);
    drain();
    chk("t2_pops", 32'(pops), 32'd5);
    chk("t2_makes", 32'(n_make), 32'd3);
    chk("t2_brks", 32'(n_brk), 32'd1);
    chk("t2_down", 32'(key_down), 32'd0);
    chk("t2_cnt", 32'(press_cnt), 32'd1);

    // Extended key press and release
    do_reset();
    push_byte(8'hE0); push_byte(8'h75);
    drain();
    chk("t3_down_mid", 32'(key_down), 32'd1);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain();
    chk("t3_code", 32'(key_code), 32'h75);
    chk("t3_ext", 32'(key_ext), 32'd1);
    chk("t3_down", 32'(key_down), 32'd0);
    chk("t3_cnt", 32'(press_cnt), 32'd1);

    // Break of a different key leaves current key held
    do_reset();
    push_byte(8'h1C); push_byte(8'h32); push_byte(8'hF0); push_byte(8'h1C);
    drain();
    chk("t4_code", 32'(key_code), 32'h32);
    chk("t4_down", 32'(key_down), 32'd1);
    chk("t4_cnt", 32'(press_cnt), 32'd2);

    // Press counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) push_byte((i % 2 == 0) ? 8'h10 : 8'h11);
    drain();
    chk("t5_cnt_ff", 32'(press_cnt), 32'hFF);
    push_byte(8'h23);
    drain();
    chk("t5_cnt_wrap", 32'(press_cnt), 32'h00);
    chk("t5_code", 32'(key_code), 32'h23);

    // Sticky overflow
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    chk("t6_ovf_set", 32'(ovf_seen), 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_ovf_hold", 32'(ovf_seen), 32'd1);
    do_reset();
    chk("t6_ovf_clr", 32'(ovf_seen), 32'd0);

    // Break prefix discarded by reset
    push_byte(8'hF0);
    drain();
    do_reset();
    push_byte(8'h1C);
    drain();
    chk("t7_makes", 32'(n_make), 32'd1);
    chk("t7_brks", 32'(n_brk), 32'd0);
    chk("t7_cnt", 32'(press_cnt), 32'd1);

    // Reset asserted while in POP: no event afterwards
    do_reset();
    push_byte(8'h1C);
    begin
      int n = 0;
      while (nextdata_n && n < 20) begin @(negedge clk); n++; end
      chk("t8_pop_seen", 32'(nextdata_n), 32'd0);
    end
    clrn = 1'b0;
    byte_q.delete(); exp_q.delete(); model_clear(); refresh();
    #1;
    chk("t8_async_nd", 32'(nextdata_n), 32'd1);
    chk("t8_async_evt", 32'(evt_valid), 32'd0);
    @(negedge clk); clrn = 1'b1;
    n_make = 0; n_brk = 0;
    repeat (6) @(negedge clk);
    chk("t8_no_evt", 32'(n_make + n_brk), 32'd0);
    chk("t8_cnt", 32'(press_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below (clock and reset first).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 ready  input  1  keyboard FIFO non-empty; data holds the head byte.
REQ-005 data  input  8  keyboard FIFO head scan-code byte.
REQ-006 overflow  input  1  keyboard FIFO overflow indication.
REQ-007 nextdata_n  output  1  active-low pop strobe to keyboard FIFO.
REQ-008 key_code  output  8  scan code of the most recent make (press) event.
REQ-009 key_ext  output  1  most recent make was E0-prefixed.
REQ-010 key_down  output  1  key named by key_code/key_ext is currently held.
REQ-011 press_cnt  output  8  count of distinct key presses, modulo 256.
REQ-012 evt_valid  output  1  one-cycle pulse per decoded make or break event.
REQ-013 evt_break  output  1  qualifies evt_valid: 1 = break, 0 = make; 0 when evt_valid=0.
REQ-014 ovf_seen  output  1  sticky flag, set once overflow has been sampled high.

Function
REQ-015 FSM states SHALL be IDLE, POP, SETTLE; all outputs registered.
REQ-016 IDLE with ready=1: capture data into byte register, go to POP; IDLE with ready=0: stay.
REQ-017 POP: nextdata_n=0 for exactly one cycle, then SETTLE; nextdata_n=1 in every other state.
REQ-018 SETTLE: one cycle with ready ignored, then IDLE; minimum byte-to-byte spacing is 3 cycles.
REQ-019 Byte decode SHALL occur in the POP cycle, using the captured byte, never the live data input.
REQ-020 Byte 0xE0: set ext_pend; no event.
REQ-021 Byte 0xF0: set brk_pend; no event.
REQ-022 Other byte with brk_pend=1: break event (evt_valid=1, evt_break=1); if byte==key_code and ext_pend==key_ext, key_down cleared; clear both pend flags.
REQ-023 Other byte with brk_pend=0, key_down=1, byte==key_code and ext_pend==key_ext: typematic repeat; make event pulsed; press_cnt unchanged; clear ext_pend.
REQ-024 Other make byte: key_code=byte, key_ext=ext_pend, key_down=1, press_cnt+1 (255 wraps to 0), make event pulsed; clear ext_pend.
REQ-025 Break of a key other than key_code/key_ext: event pulsed, key_down and key_code unchanged.
REQ-026 ovf_seen set in the cycle after overflow sampled 1; cleared only by reset.
REQ-027 evt_valid SHALL be high exactly one cycle per event (cycle after POP), and low otherwise.

Reset
REQ-028 clrn=0 SHALL immediately force: state IDLE, nextdata_n=1, key_code=0x00, key_ext=0, key_down=0, press_cnt=0x00, evt_valid=0, evt_break=0, ovf_seen=0, both pend flags 0.
REQ-029 Reset mid-sequence (e.g., after F0, or in POP) SHALL discard the partial sequence; no event after release.
REQ-030 After clrn rises, first pop SHALL occur no earlier than the second rising edge of clk.

Verification
REQ-031 FIFO bytes 1C -> nextdata_n low once, make pulse, key_code=1C, key_down=1, press_cnt=1.
REQ-032 Bytes 1C,1C,1C,F0,1C -> three make pulses, press_cnt=1, one break pulse, key_down=0, exactly 5 pops.
REQ-033 Bytes E0,75,E0,F0,75 -> key_code=75, key_ext=1, key_down 1 then 0, press_cnt=1.
REQ-034 Bytes 1C,32,F0,1C -> key_code=32, key_down=1 after break of 1C, press_cnt=2.
REQ-035 press_cnt=FF then make 23 -> press_cnt=00; overflow pulse one cycle -> ovf_seen=1 until clrn=0.
REQ-036 Bytes F0 then clrn pulsed low, then 1C -> make event (not break), press_cnt=1.
